// File: rtl/i2s_tx_serializer.sv
// ============================================================================
//  Module   : i2s_tx_serializer
//  Purpose  : I2S master transmitter with a small sample FIFO, pclk-derived SCK.
//             Optional mono replay is built when I2S_TX_MONO_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_W     = 32
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [31:0]                   controls,
    input  logic [31:0]                   Tx_data,
    input  logic                          tx_push,
    output logic                          reg_wen,
    output logic                          sck,
    output logic                          ws,
    output logic                          sd,
    output logic                          tx_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_BW = $clog2(2 * SLOT_W);
    localparam logic [c_BW-1:0] c_LAST = c_BW'(2 * SLOT_W - 1);
    localparam logic [c_BW-1:0] c_SLOT = c_BW'(SLOT_W);

    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;

    logic [7:0]      r_div_cnt;
    logic [7:0]      r_div_n;
    logic            r_sck;
    logic            r_ws;
    logic            r_sd;
    logic            r_underrun;
    logic [c_BW-1:0] r_bit_cnt;
    logic [31:0]     r_shift;
    logic [5:0]      r_wlen;

    logic            w_en;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_wrap;
    logic            w_fall;
    logic [c_BW-1:0] w_b;
    logic [c_BW-1:0] w_b_next;
    logic            w_slot;
    logic [c_BW-1:0] w_pos;
    logic            w_start;
    logic [5:0]      w_wl_new;
    logic [5:0]      w_wl;
    logic [31:0]     w_load;
    logic [31:0]     w_src;
    logic            w_active;
    logic            w_replay;
    logic            w_set_underrun;
    logic            w_unused;

`ifdef I2S_TX_MONO_EN
    logic [31:0]     r_replay;

    // Right slot of a mono frame re-sends the word captured at the left slot start.
    assign w_replay = controls[3] & w_slot;
    assign w_unused = &{1'b0, controls[31:16], controls[7:4]};
`else
    assign w_replay = 1'b0;
    assign w_unused = &{1'b0, controls[31:16], controls[7:3]};
`endif

    assign w_en     = controls[0];
    assign w_full   = (r_level == (c_AW + 1)'(FIFO_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_push   = tx_push & ~w_full;

    assign w_wrap   = w_en & (r_div_cnt >= r_div_n);
    assign w_fall   = w_wrap & r_sck;
    assign w_b      = (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + c_BW'(1);
    assign w_b_next = (w_b == c_LAST) ? '0 : w_b + c_BW'(1);
    assign w_slot   = (w_b >= c_SLOT);
    assign w_pos    = w_slot ? (w_b - c_SLOT) : w_b;
    assign w_start  = w_fall & (w_pos == '0);

    always_comb begin
        w_wl_new = 6'd32;
        case (controls[2:1])
            2'b00:   w_wl_new = 6'd16;
            2'b01:   w_wl_new = 6'd24;
            default: w_wl_new = 6'd32;
        endcase
    end

    // Right-aligned sample is left-justified so bit 31 is always the next bit out.
    assign w_load         = w_empty ? 32'd0 : (r_mem[r_rd_ptr] << (6'd32 - w_wl_new));
    assign w_pop          = w_start & ~w_empty & ~w_replay;
    assign w_set_underrun = w_start & w_empty & ~w_replay;
    assign w_wl           = w_start ? w_wl_new : r_wlen;
    assign w_active       = (32'(w_pos) < 32'(w_wl));

    always_comb begin
        w_src = r_shift;
        if (w_start) begin
`ifdef I2S_TX_MONO_EN
            w_src = w_replay ? r_replay : w_load;
`else
            w_src = w_load;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Tx_data;
        end
    end

    // Fullness is judged on the registered level, so a push while full is lost
    // even when a pop frees an entry in the same cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= r_level + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_div_cnt  <= '0;
            r_div_n    <= '0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
            r_bit_cnt  <= c_LAST;
            r_shift    <= '0;
            r_wlen     <= 6'd32;
        end else if (!w_en) begin
            r_div_cnt  <= '0;
            r_div_n    <= controls[15:8];
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
            r_bit_cnt  <= c_LAST;
        end else begin
            if (w_wrap) begin
                r_sck     <= ~r_sck;
                r_div_cnt <= '0;
                r_div_n   <= controls[15:8];
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_b;
                r_ws      <= (w_b_next >= c_SLOT);
                r_sd      <= w_active & w_src[31];
                r_shift   <= w_active ? (w_src << 1) : w_src;
                r_wlen    <= w_wl;
            end
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef I2S_TX_MONO_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_replay <= '0;
        end else if (w_start && !w_slot) begin
            r_replay <= w_load;
        end
    end
`endif

    assign reg_wen     = ~w_full;
    assign fifo_level  = r_level;
    assign sck         = r_sck;
    assign ws          = r_ws;
    assign sd          = r_sd;
    assign tx_underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
// ============================================================================
//  Module   : tb_i2s_tx_serializer
//  Purpose  : Directed, table-driven bench for i2s_tx_serializer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx_serializer;

    logic        pclk;
    logic        preset;
    logic [31:0] controls;
    logic [31:0] Tx_data;
    logic        tx_push;
    logic        reg_wen;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        tx_underrun;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    logic cap_sd  [0:255];
    logic cap_ws  [0:255];
    int   cap_per [0:255];

    typedef struct {
        logic [1:0]  wl;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs [4];

    i2s_tx_serializer #(.FIFO_DEPTH(4), .SLOT_W(32)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .controls    (controls),
        .Tx_data     (Tx_data),
        .tx_push     (tx_push),
        .reg_wen     (reg_wen),
        .sck         (sck),
        .ws          (ws),
        .sd          (sd),
        .tx_underrun (tx_underrun),
        .fifo_level  (fifo_level)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [31:0] ctl(input logic en, input logic [1:0] wl,
                                        input logic mono, input logic [7:0] n);
        return {16'h0, n, 4'h0, mono, wl, en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge pclk);
        tx_push = 1'b1;
        Tx_data = d;
        @(negedge pclk);
        tx_push = 1'b0;
    endtask

    // Skips the first SCK rise after enable (no slot data yet), then records nbits rises.
    task automatic capture(input int nbits);
        int   seen;
        int   cyc;
        logic prev;
        seen = -1;
        cyc  = 0;
        prev = sck;
        while (seen < nbits) begin
            @(negedge pclk);
            cyc++;
            if (!prev && sck) begin
                if (seen >= 0) begin
                    cap_sd[seen]  = sd;
                    cap_ws[seen]  = ws;
                    cap_per[seen] = cyc;
                end
                seen++;
                cyc = 0;
            end
            prev = sck;
            if (cyc > 64) begin
                chk("capture_timeout", 32'(seen), 32'(nbits));
                return;
            end
        end
    endtask

    function automatic logic [31:0] get_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], cap_sd[32 * k + i]};
        end
        return w;
    endfunction

    initial begin
        int   bad_ws;
        int   bad_per;
        int   cyc;
        logic prev;

        vecs[0] = '{wl: 2'b10, w0: 32'hA5A5_0001, w1: 32'h8000_0000,
                    exp_l: 32'hA5A5_0001, exp_r: 32'h8000_0000};
        vecs[1] = '{wl: 2'b00, w0: 32'h0000_1234, w1: 32'h0000_ABCD,
                    exp_l: 32'h1234_0000, exp_r: 32'hABCD_0000};
        vecs[2] = '{wl: 2'b01, w0: 32'h0012_3456, w1: 32'hFFFF_FFFF,
                    exp_l: 32'h1234_5600, exp_r: 32'hFFFF_FF00};
        vecs[3] = '{wl: 2'b11, w0: 32'hDEAD_BEEF, w1: 32'h0000_0001,
                    exp_l: 32'hDEAD_BEEF, exp_r: 32'h0000_0001};

        preset   = 1'b1;
        controls = '0;
        Tx_data  = '0;
        tx_push  = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("reset_sck", 32'(sck), 32'd0);
        chk("reset_ws", 32'(ws), 32'd0);
        chk("reset_sd", 32'(sd), 32'd0);
        chk("reset_reg_wen", 32'(reg_wen), 32'd1);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_underrun", 32'(tx_underrun), 32'd0);

        for (int v = 0; v < 4; v++) begin
            controls = ctl(1'b0, vecs[v].wl, 1'b0, 8'd1);
            push(vecs[v].w0);
            push(vecs[v].w1);
            @(negedge pclk);
            controls = ctl(1'b1, vecs[v].wl, 1'b0, 8'd1);
            capture(64);
            controls = ctl(1'b0, vecs[v].wl, 1'b0, 8'd1);
            bad_ws  = 0;
            bad_per = 0;
            for (int i = 0; i < 64; i++) begin
                if (cap_ws[i] !== ((((i + 1) % 64) >= 32) ? 1'b1 : 1'b0)) bad_ws++;
                if (cap_per[i] != 4) bad_per++;
            end
            chk($sformatf("vec%0d_left", v), get_word(0), vecs[v].exp_l);
            chk($sformatf("vec%0d_right", v), get_word(1), vecs[v].exp_r);
            chk($sformatf("vec%0d_ws_bad_bits", v), 32'(bad_ws), 32'd0);
            chk($sformatf("vec%0d_sck_bad_periods", v), 32'(bad_per), 32'd0);
            @(negedge pclk);
            chk($sformatf("vec%0d_level_after", v), 32'(fifo_level), 32'd0);
        end

        // Fill to capacity, then try one more word that must be dropped.
        controls = ctl(1'b0, 2'b10, 1'b0, 8'd1);
        push(32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        push(32'h4444_4444);
        @(negedge pclk);
        chk("full_reg_wen", 32'(reg_wen), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        push(32'h0000_DEAD);
        @(negedge pclk);
        chk("full_drop_level", 32'(fifo_level), 32'd4);
        controls = ctl(1'b1, 2'b10, 1'b0, 8'd1);
        capture(160);
        controls = ctl(1'b0, 2'b10, 1'b0, 8'd1);
        chk("drain_w0", get_word(0), 32'h1111_1111);
        chk("drain_w1", get_word(1), 32'h2222_2222);
        chk("drain_w2", get_word(2), 32'h3333_3333);
        chk("drain_w3", get_word(3), 32'h4444_4444);
        chk("drain_no_dead", get_word(4), 32'h0000_0000);
        @(negedge pclk);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("disable_clears_underrun_a", 32'(tx_underrun), 32'd0);

        // Empty FIFO: first falling tick must flag underrun and keep sd low.
        controls = ctl(1'b1, 2'b10, 1'b0, 8'd1);
        prev = sck;
        cyc  = 0;
        while (!(prev && !sck) && cyc < 50) begin
            @(negedge pclk);
            if (prev && !sck) break;
            prev = sck;
            cyc++;
        end
        chk("underrun_fall_seen", 32'(cyc < 50), 32'd1);
        chk("underrun_set", 32'(tx_underrun), 32'd1);
        chk("underrun_sd", 32'(sd), 32'd0);
        controls = ctl(1'b0, 2'b10, 1'b0, 8'd1);
        @(negedge pclk);
        chk("underrun_cleared", 32'(tx_underrun), 32'd0);
        chk("disable_sck", 32'(sck), 32'd0);

        // Reset in the middle of a frame discards FIFO and frame state.
        push(32'hCAFE_F00D);
        push(32'h0BAD_BEEF);
        controls = ctl(1'b1, 2'b10, 1'b0, 8'd1);
        capture(10);
        chk("midframe_level", 32'(fifo_level), 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        controls = '0;
        chk("midreset_level", 32'(fifo_level), 32'd0);
        chk("midreset_reg_wen", 32'(reg_wen), 32'd1);
        chk("midreset_outs", {29'd0, sck, ws, sd}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);

`ifdef I2S_TX_MONO_EN
        controls = ctl(1'b0, 2'b10, 1'b1, 8'd1);
        push(32'h0000_00FF);
        push(32'h0000_0011);
        @(negedge pclk);
        controls = ctl(1'b1, 2'b10, 1'b1, 8'd1);
        capture(64);
        controls = ctl(1'b0, 2'b10, 1'b1, 8'd1);
        chk("mono_left", get_word(0), 32'h0000_00FF);
        chk("mono_right", get_word(1), 32'h0000_00FF);
        chk("mono_level", 32'(fifo_level), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
